spidergon_switch_allocator: RTL and testbench
=============================================

Name: spidergon_switch_allocator

Overview:
- Per-node switch allocator for a spidergon node.
- Shares the three output links (ANTI_CLOCKWISE=0, CLOCKWISE=1, ACROSS=2) among four requesters: input ports 0..2 plus the local CPU injection port (requester 3).
- Wormhole allocation: an output is locked to one requester from head flit to tail flit.
- Honours per-VC ON/OFF backpressure from the downstream node. Drives the node crossbar select and the input buffer pop strobes.

Parameters:
- NUM_OF_PORTS, 3, number of network output links.
- NUM_OF_REQUESTERS, 4, input ports plus local injection.
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs per link.
- VC_WIDTH, $clog2(NUM_OF_VIRTUAL_CHANNELS), VC index width (minimum 1).
- DIRECTION_WIDTH, 2, route field width.
- HEAD_TAIL, 2, flit type field width.
- TIMEOUT_CYCLES, 64, stall limit for the optional watchdog.

Ports:
- clk  in  1  node clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_OF_REQUESTERS  requester r has a flit at its buffer head
- req_out_port  in  NUM_OF_REQUESTERS*DIRECTION_WIDTH  routed output per requester; 3 (STOP) = eject locally, never requests
- req_flit_type  in  NUM_OF_REQUESTERS*HEAD_TAIL  01 head, 10 body, 00 tail, 11 header-only
- req_vc  in  NUM_OF_REQUESTERS*VC_WIDTH  downstream VC targeted by requester r
- adjacent_node_vc_are_full  in  NUM_OF_PORTS*NUM_OF_VIRTUAL_CHANNELS  downstream VC full flags
- grant  out  NUM_OF_PORTS*NUM_OF_REQUESTERS  per-port one-hot crossbar select
- out_vc  out  NUM_OF_PORTS*VC_WIDTH  VC tag of the flit leaving on each port
- flit_data_output_are_valid  out  NUM_OF_PORTS  a flit transfers on the port this cycle
- req_pop  out  NUM_OF_REQUESTERS  requester r's flit consumed this cycle
- port_locked  out  NUM_OF_PORTS  port is mid-packet
- protocol_error  out  1  sticky error flag

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset state:
  - While reset is high, all outputs are 0 (grant, out_vc, flit_data_output_are_valid, req_pop, port_locked, protocol_error).
  - Per-port rr_ptr resets to 3, so requester 0 has first priority.
  - All port FSMs reset to IDLE.
- Reset mid-packet drops the lock. The packet is not resumed.
- Per-port FSM, states IDLE and LOCKED; registers owner and vc.
- Eligible in IDLE: requester r where:
  - req_valid[r],
  - req_out_port[r]==p,
  - flit type is 01 or 11,
  - adjacent_node_vc_are_full[p][req_vc[r]]==0.
- IDLE, winner selection:
  - Winner is the first eligible requester scanning rr_ptr+1, rr_ptr+2, ... modulo 4.
  - Grant, valid and req_pop are asserted combinationally in the same cycle: zero-cycle allocation latency.
  - out_vc = req_vc[winner].
- IDLE, next state:
  - Winner type 01 → LOCKED, owner=winner, vc latched.
  - Winner type 11 → stay IDLE.
  - In both cases rr_ptr<=winner.
- LOCKED:
  - Transfer when req_valid[owner] && req_out_port[owner]==p && !full[p][vc].
  - On transfer: grant, valid and pop are asserted; out_vc is the latched vc.
  - Tail (00) transfer → IDLE, same cycle release. New arbitration starts the next cycle.
  - Full VC → no transfer, lock held indefinitely.
  - Other requesters targeting p are never granted.
- Body or tail flit (10/00) at a requester that owns no port: no grant, and protocol_error is set.
- Head or header flit (01/11) from the owner while LOCKED: no transfer, and protocol_error is set.
- protocol_error clears only on reset.
- A requester has exactly one req_out_port, so it receives at most one grant per cycle. Different ports may grant in the same cycle.
- port_locked[p] = (state==LOCKED).

Optional Feature:
- Macro: SPIDERGON_ALLOC_TIMEOUT_EN.
- Defined:
  - Per-port counter increments each LOCKED cycle without a transfer and clears on transfer.
  - At TIMEOUT_CYCLES the port is forced to IDLE and rr_ptr<=owner.
  - Extra output alloc_timeout (NUM_OF_PORTS) pulses for one cycle.
- Undefined: no counter, no alloc_timeout port; a lock persists until the tail flit.

Decomposition:
- Package spidergon_pkg:
  - Flit type constants HEAD_FLIT, BODY_FLIT, TAIL_FLIT, HEADER.
  - Direction constants ANTI_CLOCKWISE, CLOCKWISE, ACROSS, STOP.
  - Port FSM state enum.
- Sub-module spidergon_rr_arbiter:
  - 4-way rotating-priority arbiter with pointer input and one-hot output.
  - Instantiated once per output port.

Test Plan:
- Reset then single header flit: r0 valid, port 1, type 11, vc 0 → grant[1]=0001, pop r0 in the same cycle. Port stays IDLE; rr_ptr[1]=0.
- Wormhole lock: r2 sends head, body, body, tail on port 2 while r3 continuously offers a head on port 2.
  - r3 is never granted during those 4 transfers.
  - r3 is granted the cycle after the tail.
- Round robin: r0, r1 and r3 hold header flits to port 0 every cycle → grant order r0, r1, r3, r0.
- Backpressure: r1 locked on port 0, vc 1.
  - full[0][1]=1 for 5 cycles → no valid and no pop for those cycles, lock held.
  - Flow resumes the cycle full deasserts.
  - A head on vc 0 from r2 stays blocked.
- Parallel ports and errors:
  - r0→port 0 and r1→port 2 heads in the same cycle → both granted.
  - Body flit from unlocked r3 → protocol_error=1 and stays 1 until reset.
- With SPIDERGON_ALLOC_TIMEOUT_EN and TIMEOUT_CYCLES=8: owner stalls (req_valid=0) after its head → alloc_timeout[p] pulses after 8 cycles and the port returns to IDLE.

Source files
------------

// File: rtl/spidergon_pkg.sv
// Shared definitions for the spidergon node switch allocator: flit types,
// route directions and the per-output-port lock FSM state.
package spidergon_pkg;

    localparam logic [1:0] HEAD_FLIT = 2'b01;
    localparam logic [1:0] BODY_FLIT = 2'b10;
    localparam logic [1:0] TAIL_FLIT = 2'b00;
    localparam logic [1:0] HEADER    = 2'b11;

    localparam logic [1:0] ANTI_CLOCKWISE = 2'd0;
    localparam logic [1:0] CLOCKWISE      = 2'd1;
    localparam logic [1:0] ACROSS         = 2'd2;
    localparam logic [1:0] STOP           = 2'd3;

    typedef enum logic {
        IDLE,
        LOCKED
    } port_state_t;

    // Flits that may open a new allocation (head or single-flit header).
    function automatic logic is_head_type(input logic [1:0] flit_type);
        return (flit_type == HEAD_FLIT) || (flit_type == HEADER);
    endfunction

endpackage

// File: rtl/spidergon_rr_arbiter.sv
// Rotating-priority arbiter: the requester just after ptr has highest
// priority; the grant is one-hot (or zero when nothing requests).
module spidergon_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spidergon_switch_allocator.sv
// Per-node wormhole switch allocator for a spidergon router (3 links, 4 requesters).
// Optional stall watchdog enabled by defining SPIDERGON_ALLOC_TIMEOUT_EN.
module spidergon_switch_allocator
    import spidergon_pkg::*;
#(
    parameter int NUM_OF_PORTS            = 3,
    parameter int NUM_OF_REQUESTERS       = 4,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int VC_WIDTH                = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1,
    parameter int DIRECTION_WIDTH         = 2,
    parameter int HEAD_TAIL               = 2,
    parameter int TIMEOUT_CYCLES          = 64
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_OF_REQUESTERS-1:0]                  req_valid,
    input  logic [NUM_OF_REQUESTERS*DIRECTION_WIDTH-1:0]  req_out_port,
    input  logic [NUM_OF_REQUESTERS*HEAD_TAIL-1:0]        req_flit_type,
    input  logic [NUM_OF_REQUESTERS*VC_WIDTH-1:0]         req_vc,
    input  logic [NUM_OF_PORTS*NUM_OF_VIRTUAL_CHANNELS-1:0] adjacent_node_vc_are_full,
    output logic [NUM_OF_PORTS*NUM_OF_REQUESTERS-1:0]     grant,
    output logic [NUM_OF_PORTS*VC_WIDTH-1:0]              out_vc,
    output logic [NUM_OF_PORTS-1:0]                       flit_data_output_are_valid,
    output logic [NUM_OF_REQUESTERS-1:0]                  req_pop,
    output logic [NUM_OF_PORTS-1:0]                       port_locked,
    output logic                                          protocol_error
`ifdef SPIDERGON_ALLOC_TIMEOUT_EN
    ,
    output logic [NUM_OF_PORTS-1:0]                       alloc_timeout
`endif
);

    localparam int NP = NUM_OF_PORTS;
    localparam int NR = NUM_OF_REQUESTERS;
    localparam int NV = NUM_OF_VIRTUAL_CHANNELS;
    localparam int RW = $clog2(NR);

    logic [DIRECTION_WIDTH-1:0] rq_port [NR];
    logic [HEAD_TAIL-1:0]       rq_type [NR];
    logic [VC_WIDTH-1:0]        rq_vc   [NR];

    port_state_t          state      [NP];
    port_state_t          state_next [NP];
    logic [RW-1:0]        owner      [NP];
    logic [RW-1:0]        owner_next [NP];
    logic [VC_WIDTH-1:0]  vc_q       [NP];
    logic [VC_WIDTH-1:0]  vc_next    [NP];
    logic [RW-1:0]        rr_ptr     [NP];
    logic [RW-1:0]        rr_next    [NP];

    logic [NR-1:0]        eligible   [NP];
    logic [NR-1:0]        arb_grant  [NP];
    logic [NP-1:0]        win_any;
    logic [RW-1:0]        win_idx    [NP];
    logic [NP-1:0]        xfer;
    logic [NP-1:0]        timeout_hit;
    logic                 err_now;
    logic                 err_q;

`ifdef SPIDERGON_ALLOC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     stall_cnt      [NP];
    logic [CNT_W-1:0]     stall_cnt_next [NP];
`endif

    always_comb begin
        for (int unsigned r = 0; r < NR; r++) begin
            rq_port[r] = req_out_port[r*DIRECTION_WIDTH +: DIRECTION_WIDTH];
            rq_type[r] = req_flit_type[r*HEAD_TAIL +: HEAD_TAIL];
            rq_vc[r]   = req_vc[r*VC_WIDTH +: VC_WIDTH];
        end
    end

    // New packets compete only when their target VC downstream has room.
    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            for (int unsigned r = 0; r < NR; r++) begin
                eligible[p][r] = req_valid[r]
                              && (rq_port[r] == DIRECTION_WIDTH'(p))
                              && is_head_type(rq_type[r])
                              && !adjacent_node_vc_are_full[p*NV + int'(rq_vc[r])];
            end
        end
    end

    for (genvar gp = 0; gp < NP; gp++) begin : g_arb
        spidergon_rr_arbiter #(
            .N     (NR),
            .PTR_W (RW)
        ) u_arb (
            .req   (eligible[gp]),
            .ptr   (rr_ptr[gp]),
            .grant (arb_grant[gp])
        );
    end

    always_comb begin
        timeout_hit = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            win_any[p] = |arb_grant[p];
            win_idx[p] = '0;
            for (int unsigned r = 0; r < NR; r++) begin
                if (arb_grant[p][r]) win_idx[p] = RW'(r);
            end
            xfer[p] = (state[p] == LOCKED)
                   && req_valid[owner[p]]
                   && (rq_port[owner[p]] == DIRECTION_WIDTH'(p))
                   && !is_head_type(rq_type[owner[p]])
                   && !adjacent_node_vc_are_full[p*NV + int'(vc_q[p])];
`ifdef SPIDERGON_ALLOC_TIMEOUT_EN
            timeout_hit[p] = (state[p] == LOCKED) && !xfer[p]
                          && (stall_cnt[p] == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
        end
    end

    // Protocol checks: continuation flits need an owned port, and an owner
    // must not start a new packet before its tail has left.
    always_comb begin
        logic owns;
        err_now = 1'b0;
        for (int unsigned r = 0; r < NR; r++) begin
            owns = 1'b0;
            for (int unsigned p = 0; p < NP; p++) begin
                if ((state[p] == LOCKED) && (owner[p] == RW'(r))) owns = 1'b1;
            end
            if (req_valid[r] && (rq_port[r] != STOP) && !is_head_type(rq_type[r]) && !owns)
                err_now = 1'b1;
        end
        for (int unsigned p = 0; p < NP; p++) begin
            if ((state[p] == LOCKED) && req_valid[owner[p]] && is_head_type(rq_type[owner[p]]))
                err_now = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned p = 0; p < NP; p++) begin
                state[p]  <= IDLE;
                owner[p]  <= '0;
                vc_q[p]   <= '0;
                rr_ptr[p] <= RW'(NR - 1);
`ifdef SPIDERGON_ALLOC_TIMEOUT_EN
                stall_cnt[p] <= '0;
`endif
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                state[p]  <= state_next[p];
                owner[p]  <= owner_next[p];
                vc_q[p]   <= vc_next[p];
                rr_ptr[p] <= rr_next[p];
`ifdef SPIDERGON_ALLOC_TIMEOUT_EN
                stall_cnt[p] <= stall_cnt_next[p];
`endif
            end
            if (err_now) err_q <= 1'b1;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            state_next[p] = state[p];
            owner_next[p] = owner[p];
            vc_next[p]    = vc_q[p];
            rr_next[p]    = rr_ptr[p];
            unique case (state[p])
                IDLE: begin
                    if (win_any[p]) begin
                        rr_next[p] = win_idx[p];
                        if (rq_type[win_idx[p]] == HEAD_FLIT) begin
                            state_next[p] = LOCKED;
                            owner_next[p] = win_idx[p];
                            vc_next[p]    = rq_vc[win_idx[p]];
                        end
                    end
                end
                LOCKED: begin
                    if (xfer[p] && (rq_type[owner[p]] == TAIL_FLIT)) state_next[p] = IDLE;
                    if (timeout_hit[p]) begin
                        state_next[p] = IDLE;
                        rr_next[p]    = owner[p];
                    end
                end
                default: state_next[p] = IDLE;
            endcase
`ifdef SPIDERGON_ALLOC_TIMEOUT_EN
            if ((state[p] == LOCKED) && !xfer[p] && !timeout_hit[p])
                stall_cnt_next[p] = stall_cnt[p] + 1'b1;
            else
                stall_cnt_next[p] = '0;
`endif
        end
    end

    // Allocation is zero-latency: grant, valid and pop follow the inputs combinationally.
    always_comb begin
        logic [NR-1:0] g;
        grant                      = '0;
        out_vc                     = '0;
        flit_data_output_are_valid = '0;
        req_pop                    = '0;
        port_locked                = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            g = '0;
            if (!reset) begin
                if ((state[p] == IDLE) && win_any[p]) begin
                    g                             = arb_grant[p];
                    flit_data_output_are_valid[p] = 1'b1;
                    out_vc[p*VC_WIDTH +: VC_WIDTH] = rq_vc[win_idx[p]];
                end else if ((state[p] == LOCKED) && xfer[p]) begin
                    g[owner[p]]                   = 1'b1;
                    flit_data_output_are_valid[p] = 1'b1;
                    out_vc[p*VC_WIDTH +: VC_WIDTH] = vc_q[p];
                end
                port_locked[p] = (state[p] == LOCKED);
            end
            grant[p*NR +: NR] = g;
            req_pop           = req_pop | g;
        end
    end

    assign protocol_error = err_q & ~reset;

`ifdef SPIDERGON_ALLOC_TIMEOUT_EN
    assign alloc_timeout = timeout_hit & {NP{~reset}};
`endif

endmodule

// File: tb/tb_spidergon_switch_allocator.sv
// Directed self-checking bench for spidergon_switch_allocator (default build).
module tb_spidergon_switch_allocator;
    import spidergon_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [7:0]  req_out_port;
    logic [7:0]  req_flit_type;
    logic [3:0]  req_vc;
    logic [5:0]  full;
    logic [11:0] grant;
    logic [2:0]  out_vc;
    logic [2:0]  flit_valid;
    logic [3:0]  req_pop;
    logic [2:0]  port_locked;
    logic        protocol_error;

    int tests_run    = 0;
    int tests_failed = 0;

    spidergon_switch_allocator dut (
        .clk                        (clk),
        .reset                      (reset),
        .req_valid                  (req_valid),
        .req_out_port               (req_out_port),
        .req_flit_type              (req_flit_type),
        .req_vc                     (req_vc),
        .adjacent_node_vc_are_full  (full),
        .grant                      (grant),
        .out_vc                     (out_vc),
        .flit_data_output_are_valid (flit_valid),
        .req_pop                    (req_pop),
        .port_locked                (port_locked),
        .protocol_error             (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] port,
                           input logic [1:0] ft, input logic vc);
        req_valid[r]           = v;
        req_out_port[r*2 +: 2] = port;
        req_flit_type[r*2 +: 2] = ft;
        req_vc[r]              = vc;
    endtask

    task automatic clear_all();
        req_valid     = '0;
        req_out_port  = '1;
        req_flit_type = '0;
        req_vc        = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] rr_exp [4];

    initial begin
        rr_exp[0] = 12'h001; rr_exp[1] = 12'h002; rr_exp[2] = 12'h008; rr_exp[3] = 12'h001;
        reset = 1'b1;
        full  = '0;
        clear_all();
        set_req(0, 1'b1, 2'd1, HEADER, 1'b0);
        tick(); tick();
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_pop", 32'(req_pop), 32'h0);
        check_eq("rst_valid", 32'(flit_valid), 32'h0);
        check_eq("rst_locked", 32'(port_locked), 32'h0);
        check_eq("rst_err", 32'(protocol_error), 32'h0);

        // single header flit, granted in the same cycle
        reset = 1'b0;
        #1;
        check_eq("hdr_grant", 32'(grant), 32'h010);
        check_eq("hdr_pop", 32'(req_pop), 32'h1);
        check_eq("hdr_valid", 32'(flit_valid), 32'h2);
        check_eq("hdr_out_vc", 32'(out_vc), 32'h0);
        tick();
        check_eq("hdr_not_locked", 32'(port_locked), 32'h0);
        set_req(1, 1'b1, 2'd1, HEADER, 1'b1);
        #1;
        check_eq("hdr_rr_next", 32'(grant), 32'h020);
        check_eq("hdr_rr_vc", 32'(out_vc), 32'h2);
        tick();
        clear_all();

        // round robin on port 0
        set_req(0, 1'b1, 2'd0, HEADER, 1'b0);
        set_req(1, 1'b1, 2'd0, HEADER, 1'b0);
        set_req(3, 1'b1, 2'd0, HEADER, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_%0d", i), 32'(grant), 32'(rr_exp[i]));
            tick();
        end
        clear_all();

        // wormhole lock on port 2: r3 waits behind r2's packet
        set_req(2, 1'b1, 2'd2, HEAD_FLIT, 1'b1);
        set_req(3, 1'b1, 2'd2, HEAD_FLIT, 1'b0);
        #1;
        check_eq("wh_head_grant", 32'(grant), 32'h400);
        check_eq("wh_head_pop", 32'(req_pop), 32'h4);
        check_eq("wh_head_vc", 32'(out_vc), 32'h4);
        tick();
        check_eq("wh_locked", 32'(port_locked), 32'h4);
        for (int i = 0; i < 3; i++) begin
            set_req(2, 1'b1, 2'd2, (i == 2) ? TAIL_FLIT : BODY_FLIT, 1'b1);
            #1;
            check_eq($sformatf("wh_flit%0d_grant", i), 32'(grant), 32'h400);
            check_eq($sformatf("wh_flit%0d_pop", i), 32'(req_pop), 32'h4);
            tick();
        end
        set_req(2, 1'b0, 2'd3, TAIL_FLIT, 1'b0);
        #1;
        check_eq("wh_r3_grant", 32'(grant), 32'h800);
        check_eq("wh_r3_pop", 32'(req_pop), 32'h8);
        check_eq("wh_r3_vc", 32'(out_vc), 32'h0);
        tick();
        set_req(3, 1'b1, 2'd2, TAIL_FLIT, 1'b0);
        #1;
        check_eq("wh_r3_tail", 32'(grant), 32'h800);
        tick();
        clear_all();
        #1;
        check_eq("wh_released", 32'(port_locked), 32'h0);
        check_eq("wh_no_err", 32'(protocol_error), 32'h0);

        // backpressure on port 0 vc 1
        set_req(1, 1'b1, 2'd0, HEAD_FLIT, 1'b1);
        #1;
        check_eq("bp_head", 32'(grant), 32'h002);
        tick();
        set_req(1, 1'b1, 2'd0, BODY_FLIT, 1'b1);
        set_req(2, 1'b1, 2'd0, HEAD_FLIT, 1'b0);
        full = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("bp_stall%0d_valid", i), 32'(flit_valid), 32'h0);
            check_eq($sformatf("bp_stall%0d_pop", i), 32'(req_pop), 32'h0);
            tick();
            check_eq($sformatf("bp_stall%0d_locked", i), 32'(port_locked), 32'h1);
        end
        full = '0;
        #1;
        check_eq("bp_resume_grant", 32'(grant), 32'h002);
        check_eq("bp_resume_vc", 32'(out_vc), 32'h1);
        check_eq("bp_resume_pop", 32'(req_pop), 32'h2);
        tick();
        set_req(1, 1'b1, 2'd0, TAIL_FLIT, 1'b1);
        #1;
        check_eq("bp_tail", 32'(grant), 32'h002);
        tick();
        set_req(1, 1'b0, 2'd3, TAIL_FLIT, 1'b0);
        #1;
        check_eq("bp_r2_grant", 32'(grant), 32'h004);
        check_eq("bp_r2_vc", 32'(out_vc), 32'h0);
        tick();
        set_req(2, 1'b1, 2'd0, TAIL_FLIT, 1'b0);
        #1;
        check_eq("bp_r2_tail", 32'(grant), 32'h004);
        tick();
        clear_all();

        // parallel allocation on ports 0 and 2
        set_req(0, 1'b1, 2'd0, HEAD_FLIT, 1'b0);
        set_req(1, 1'b1, 2'd2, HEAD_FLIT, 1'b1);
        #1;
        check_eq("par_grant", 32'(grant), 32'h201);
        check_eq("par_valid", 32'(flit_valid), 32'h5);
        check_eq("par_pop", 32'(req_pop), 32'h3);
        check_eq("par_vc", 32'(out_vc), 32'h4);
        tick();
        check_eq("par_locked", 32'(port_locked), 32'h5);
        set_req(0, 1'b1, 2'd0, TAIL_FLIT, 1'b0);
        set_req(1, 1'b1, 2'd2, TAIL_FLIT, 1'b1);
        #1;
        check_eq("par_tails", 32'(grant), 32'h201);
        tick();
        clear_all();
        #1;
        check_eq("par_released", 32'(port_locked), 32'h0);
        check_eq("par_no_err", 32'(protocol_error), 32'h0);

        // body flit from a requester that owns nothing
        set_req(3, 1'b1, 2'd1, BODY_FLIT, 1'b0);
        #1;
        check_eq("err_no_grant", 32'(grant), 32'h0);
        tick();
        check_eq("err_set", 32'(protocol_error), 32'h1);
        clear_all();
        tick(); tick();
        check_eq("err_sticky", 32'(protocol_error), 32'h1);

        // reset mid-packet drops the lock
        set_req(0, 1'b1, 2'd0, HEAD_FLIT, 1'b0);
        tick();
        check_eq("mid_locked", 32'(port_locked), 32'h1);
        clear_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(2, 1'b1, 2'd0, HEAD_FLIT, 1'b0);
        #1;
        check_eq("mid_unlocked", 32'(port_locked), 32'h0);
        check_eq("mid_err_clr", 32'(protocol_error), 32'h0);
        check_eq("mid_new_grant", 32'(grant), 32'h004);
        tick();
        clear_all();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
